// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory bus controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

  localparam int CNT_W = 4;

  // Byte offset of the accessed lane; words and halfwords are forced aligned.
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] a);
    logic [1:0] off;
    case (size)
      SZ_HALF: off = {a[1], 1'b0};
      SZ_BYTE: off = a;
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_HALF: be = 4'b0011 << {a[1], 1'b0};
      SZ_BYTE: be = 4'b0001 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      SZ_HALF: m = 32'h0000_FFFF;
      SZ_BYTE: m = 32'h0000_00FF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic mis;
    case (size)
      SZ_HALF: mis = a[0];
      SZ_BYTE: mis = 1'b0;
      default: mis = (a != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Word-organised SRAM with per-byte write enables and a combinational read port.
module dmem_sram import dmem_pkg::*; #(
  parameter int DEPTH_W = 12
) (
  input  logic               clk,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [3:0]         wbe,
  input  logic [31:0]        wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [31:0]        rdata
);

  logic [31:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-bus controller: latches a core request, inserts wait states, then acks with SRAM data.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned half/word accesses on ERR instead of forcing alignment.
module dmem_bus_ctrl import dmem_pkg::*; #(
  parameter int DEPTH_W     = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic [31:0] DAD,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n,
  output logic        ERR
);

  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH_W+1:0] addr_q, addr_d;
  logic               write_q, write_d;
  logic [1:0]         size_q, size_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [DEPTH_W+1:0] req_addr;
  logic [1:0]         req_size;
  logic [1:0]         req_off;
  logic               req_err;
  logic               ack_err;
  logic [31:0]        load_data;
  logic [31:0]        sram_rdata;
  logic [31:0]        sram_wdata;
  logic [3:0]         sram_wbe;
  logic               addr_hi_unused;

  assign addr_hi_unused = ^DAD[31:DEPTH_W+2];

  // With zero wait states the SRAM is read in the same cycle the request is latched,
  // so the read path looks at the live bus while idle and the latched copy otherwise.
  always_comb begin
    req_addr = (state_q == ST_IDLE) ? DAD[DEPTH_W+1:0] : addr_q;
    req_size = (state_q == ST_IDLE) ? SIZE : size_q;
    req_off  = lane_off(req_size, req_addr[1:0]);
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_err = is_misaligned(req_size, req_addr[1:0]);
  assign ack_err = is_misaligned(size_q, addr_q[1:0]);
  assign ERR     = (state_q == ST_ACK) && ack_err;
`else
  assign req_err = 1'b0;
  assign ack_err = 1'b0;
  assign ERR     = 1'b0;
`endif

  always_comb begin
    load_data = (sram_rdata >> {req_off, 3'b000}) & size_mask(req_size);
    if (req_err) load_data = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (MREQ) begin
          addr_d  = DAD[DEPTH_W+1:0];
          write_d = WRITE;
          size_d  = SIZE;
          wdata_d = DDT;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_ACK) && (state_q != ST_ACK)) rdata_d = load_data;
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= SZ_WORD;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Store commits on the edge leaving ACK, so a reset before then drops it.
  always_comb begin
    sram_wdata = wdata_q << {lane_off(size_q, addr_q[1:0]), 3'b000};
    sram_wbe   = '0;
    if ((state_q == ST_ACK) && write_q && !ack_err) sram_wbe = byte_en(size_q, addr_q[1:0]);
  end

  dmem_sram #(.DEPTH_W(DEPTH_W)) u_sram (
    .clk   (clk),
    .waddr (addr_q[DEPTH_W+1:2]),
    .wbe   (sram_wbe),
    .wdata (sram_wdata),
    .raddr (req_addr[DEPTH_W+1:2]),
    .rdata (sram_rdata)
  );

  assign ACKD_n = (state_q != ST_ACK);
  assign DDT    = ((state_q == ST_ACK) && !write_q) ? rdata_q : 'z;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: one instance with two wait states, one with none.
// DDT nets are pulled high so a released bus reads as all ones in any simulator.
module tb_dmem_bus_ctrl;
  import dmem_pkg::*;

  localparam int          W0    = 2;
  localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_x = 1'b0;

  logic        mreq0, write0, drv0;
  logic [1:0]  size0;
  logic [31:0] dad0, dout0;
  logic        ack_n0, err0;
  tri1  [31:0] ddt0;

  logic        mreq1, write1, drv1;
  logic [1:0]  size1;
  logic [31:0] dad1, dout1;
  logic        ack_n1, err1;
  tri1  [31:0] ddt1;

  int checks = 0;
  int failures = 0;

  assign ddt0 = drv0 ? dout0 : 'z;
  assign ddt1 = drv1 ? dout1 : 'z;

  always #5 clk = ~clk;

  dmem_bus_ctrl #(.DEPTH_W(12), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .reset_x(reset_x), .DAD(dad0), .MREQ(mreq0), .WRITE(write0),
    .SIZE(size0), .DDT(ddt0), .ACKD_n(ack_n0), .ERR(err0)
  );

  dmem_bus_ctrl #(.DEPTH_W(12), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset_x(reset_x), .DAD(dad1), .MREQ(mreq1), .WRITE(write1),
    .SIZE(size1), .DDT(ddt1), .ACKD_n(ack_n1), .ERR(err1)
  );

  // One access on dut0; lat counts negedges from the sampling edge to ACK (0 = timed out).
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat);
    @(negedge clk);
    mreq0 = 1'b1; write0 = wr; size0 = sz; dad0 = addr; dout0 = wd; drv0 = wr;
    @(posedge clk);
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (ack_n0 == 1'b0) begin
        lat = i; rd = ddt0; er = err0;
        break;
      end
    end
    mreq0 = 1'b0; drv0 = 1'b0;
  endtask

  task automatic test_reset();
    mreq0 = 0; write0 = 0; size0 = 0; dad0 = 0; dout0 = 0; drv0 = 0;
    mreq1 = 0; write1 = 0; size1 = 0; dad1 = 0; dout1 = 0; drv1 = 0;
    reset_x = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ack_n0 !== 1'b1) begin failures++; $display("[TB] FAIL reset_ack_n0 got=%b exp=1", ack_n0); end
    checks++; if (err0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_err0 got=%b exp=0", err0); end
    checks++; if (ddt0 !== FLOAT) begin failures++; $display("[TB] FAIL reset_ddt0 got=%h exp=%h", ddt0, FLOAT); end
    checks++; if (ack_n1 !== 1'b1) begin failures++; $display("[TB] FAIL reset_ack_n1 got=%b exp=1", ack_n1); end
    checks++; if (ddt1 !== FLOAT) begin failures++; $display("[TB] FAIL reset_ddt1 got=%h exp=%h", ddt1, FLOAT); end
    reset_x = 1'b1;
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, SZ_WORD, 32'h100, 32'hDEAD_BEEF, rd, er, lat);
    checks++; if (lat !== W0 + 1) begin failures++; $display("[TB] FAIL store_latency got=%0d exp=%0d", lat, W0 + 1); end
    checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL store_err got=%b exp=0", er); end
    do_access(1'b0, SZ_WORD, 32'h100, 32'h0, rd, er, lat);
    checks++; if (lat !== W0 + 1) begin failures++; $display("[TB] FAIL load_latency got=%0d exp=%0d", lat, W0 + 1); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL load_word got=%h exp=deadbeef", rd); end
    @(negedge clk);
    checks++; if (ack_n0 !== 1'b1) begin failures++; $display("[TB] FAIL ack_one_cycle got=%b exp=1", ack_n0); end
    checks++; if (ddt0 !== FLOAT) begin failures++; $display("[TB] FAIL ddt_released got=%h exp=%h", ddt0, FLOAT); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] la [5] = '{32'h200, 32'h202, 32'h203, 32'h201, 32'h200};
    logic [1:0]  ls [5] = '{SZ_WORD, SZ_HALF, SZ_BYTE, SZ_BYTE, SZ_HALF};
    logic [31:0] le [5] = '{32'h4433_2211, 32'h0000_4433, 32'h0000_0044, 32'h0000_0022, 32'h0000_2211};
    for (int i = 0; i < 4; i++) begin
      do_access(1'b1, SZ_BYTE, 32'h200 + i, 32'(8'h11 * (i + 1)), rd, er, lat);
      checks++; if (lat !== W0 + 1) begin failures++; $display("[TB] FAIL byte_store_latency[%0d] got=%0d exp=%0d", i, lat, W0 + 1); end
    end
    for (int i = 0; i < 5; i++) begin
      do_access(1'b0, ls[i], la[i], 32'h0, rd, er, lat);
      checks++; if (rd !== le[i]) begin failures++; $display("[TB] FAIL lane_load[%0d] got=%h exp=%h", i, rd, le[i]); end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int lat; int acks;
    do_access(1'b1, SZ_WORD, 32'h10, 32'h1234_5678, rd, er, lat);
    @(negedge clk);
    mreq0 = 1'b1; write0 = 1'b1; size0 = SZ_WORD; dad0 = 32'h10; dout0 = 32'hCAFE_F00D; drv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_x = 1'b0; mreq0 = 1'b0; drv0 = 1'b0;
    #1;
    checks++; if (ddt0 !== FLOAT) begin failures++; $display("[TB] FAIL reset_mid_ddt got=%h exp=%h", ddt0, FLOAT); end
    @(negedge clk);
    reset_x = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_n0 == 1'b0) acks++;
    end
    checks++; if (acks !== 0) begin failures++; $display("[TB] FAIL reset_mid_no_ack got=%0d exp=0", acks); end
    do_access(1'b0, SZ_WORD, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("[TB] FAIL reset_mid_store_dropped got=%h exp=12345678", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, SZ_WORD, 32'h4000_0004, 32'h0BAD_F00D, rd, er, lat);
    do_access(1'b0, SZ_WORD, 32'h0000_0004, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0BAD_F00D) begin failures++; $display("[TB] FAIL addr_wrap got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_align();
    logic [31:0] rd; logic er; int lat;
    logic        exp_err;
    logic [31:0] exp_word, exp_half;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_err = 1'b1; exp_word = 32'hA1B2_C3D4; exp_half = 32'h0000_0000;
`else
    exp_err = 1'b0; exp_word = 32'hA1B2_5566; exp_half = 32'h0000_A1B2;
`endif
    do_access(1'b1, SZ_WORD, 32'h300, 32'hA1B2_C3D4, rd, er, lat);
    do_access(1'b1, SZ_HALF, 32'h301, 32'h0000_5566, rd, er, lat);
    checks++; if (er !== exp_err) begin failures++; $display("[TB] FAIL misaligned_store_err got=%b exp=%b", er, exp_err); end
    checks++; if (lat !== W0 + 1) begin failures++; $display("[TB] FAIL misaligned_store_latency got=%0d exp=%0d", lat, W0 + 1); end
    do_access(1'b0, SZ_WORD, 32'h300, 32'h0, rd, er, lat);
    checks++; if (rd !== exp_word) begin failures++; $display("[TB] FAIL misaligned_store_mem got=%h exp=%h", rd, exp_word); end
    do_access(1'b0, SZ_HALF, 32'h303, 32'h0, rd, er, lat);
    checks++; if (rd !== exp_half) begin failures++; $display("[TB] FAIL misaligned_load got=%h exp=%h", rd, exp_half); end
    checks++; if (er !== exp_err) begin failures++; $display("[TB] FAIL misaligned_load_err got=%b exp=%b", er, exp_err); end
  endtask

  // Zero-wait instance, MREQ held high: store, then two loads of the same word.
  task automatic test_back_to_back();
    logic exp_ack [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    mreq1 = 1'b1; write1 = 1'b1; size1 = SZ_WORD; dad1 = 32'h40; dout1 = 32'h600D_CAFE; drv1 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (ack_n1 !== exp_ack[k]) begin failures++; $display("[TB] FAIL b2b_ack[%0d] got=%b exp=%b", k, ack_n1, exp_ack[k]); end
      checks++;
      if (exp_ack[k]) begin
        if (ddt1 !== FLOAT) begin failures++; $display("[TB] FAIL b2b_ddt_idle[%0d] got=%h exp=%h", k, ddt1, FLOAT); end
      end else begin
        if (ddt1 !== 32'h600D_CAFE) begin failures++; $display("[TB] FAIL b2b_ddt_ack[%0d] got=%h exp=600dcafe", k, ddt1); end
      end
      if (k == 0) begin write1 = 1'b0; drv1 = 1'b0; end
      if (k == 4) mreq1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_lanes();
    test_reset_mid_access();
    test_wrap();
    test_align();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
